// File: rtl/e203_wfi_ctrl_pkg.sv
// Shared definitions for the WFI sleep sequencer: state encodings and default sizing.
package e203_wfi_ctrl_pkg;

    typedef enum logic [1:0] {
        WFI_IDLE  = 2'd0,
        WFI_DRAIN = 2'd1,
        WFI_SLEEP = 2'd2,
        WFI_WAKE  = 2'd3
    } wfi_state_e;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_WAKE_LAT = 2;
    // Wide enough for the largest legal WAKE_LAT (7).
    localparam int WAKE_W       = 3;

endpackage

// File: rtl/e203_wfi_ctrl_if.sv
// Signal bundle between the commit/EXU/CSR side and the WFI sequencer.
interface e203_wfi_ctrl_if
    import e203_wfi_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             wfi_req;
    logic             wfi_ack;
    logic             halt_req;
    logic             pipe_idle;
    logic             irq_pending;
    logic             dbg_req;
    logic             sleep_value;
    logic [CNT_W-1:0] idle_thresh;
    logic             core_wfi;
    logic             deep_sleep_req;
    logic             wfi_wake;
    logic [CNT_W-1:0] sleep_cnt;

    modport slave (
        input  wfi_req, pipe_idle, irq_pending, dbg_req, sleep_value, idle_thresh,
        output wfi_ack, halt_req, core_wfi, deep_sleep_req, wfi_wake, sleep_cnt
    );

    modport master (
        output wfi_req, pipe_idle, irq_pending, dbg_req, sleep_value, idle_thresh,
        input  wfi_ack, halt_req, core_wfi, deep_sleep_req, wfi_wake, sleep_cnt
    );
endinterface

// File: rtl/e203_wfi_sat_cnt.sv
// Saturating up-counter with synchronous clear and enable; exposes its next value
// so callers can compare against the count that will be visible next cycle.
module e203_wfi_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_cnt_nxt
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_nxt;

    always_comb begin
        w_nxt = r_cnt;
        if (i_clr) begin
            w_nxt = '0;
        end else if (i_en && (r_cnt != '1)) begin
            w_nxt = r_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_nxt;
endmodule

// File: rtl/e203_wfi_ctrl.sv
// WFI sleep sequencer on the always-on clock: drains the pipe, gates the IFU clock via
// core_wfi, times the sleep and requests deep sleep from the PMU past a threshold.
module e203_wfi_ctrl
    import e203_wfi_ctrl_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WAKE_LAT = DEF_WAKE_LAT
) (
    input logic             clk,
    input logic             rst_n,
    e203_wfi_ctrl_if.slave  bus
);
    wfi_state_e        r_state;
    wfi_state_e        w_state_nxt;
    logic [WAKE_W-1:0] r_wait;
    logic [WAKE_W-1:0] w_wait_nxt;
    logic              r_ack;
    logic              r_wake;
    logic              r_deep;
    logic              r_sv;
    logic              w_wake_in;
    logic              w_accept;
    logic              w_drain_entry;
    logic              w_wake_done;
    logic              w_deep_nxt;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_wake_in     = bus.irq_pending | bus.dbg_req;
    assign w_drain_entry = w_accept & ~w_wake_in;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wake_done = 1'b0;
        case (r_state)
            WFI_IDLE: begin
                if (bus.wfi_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_wake_in ? WFI_WAKE : WFI_DRAIN;
                end
            end
            WFI_DRAIN: begin
                if (w_wake_in) begin
                    w_state_nxt = WFI_WAKE;
                end else if (bus.pipe_idle) begin
                    w_state_nxt = WFI_SLEEP;
                end
            end
            WFI_SLEEP: begin
                if (w_wake_in) begin
                    w_state_nxt = WFI_WAKE;
                end
            end
            WFI_WAKE: begin
                if (r_wait == '0) begin
                    w_wake_done = 1'b1;
                    w_state_nxt = WFI_IDLE;
                end
            end
            default: w_state_nxt = WFI_IDLE;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait;
        if ((r_state != WFI_WAKE) && (w_state_nxt == WFI_WAKE)) begin
            w_wait_nxt = WAKE_W'(WAKE_LAT);
        end else if (r_wait != '0) begin
            w_wait_nxt = r_wait - WAKE_W'(1);
        end
    end

    // Deep-sleep is registered off the counter's next value so it rises with sleep_cnt
    // reaching the threshold and falls on the same edge that leaves SLEEP.
    assign w_deep_nxt = (w_state_nxt == WFI_SLEEP) && r_sv &&
                        (bus.idle_thresh != '0) && (w_cnt_nxt >= bus.idle_thresh);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= WFI_IDLE;
            r_wait  <= '0;
            r_ack   <= 1'b0;
            r_wake  <= 1'b0;
            r_deep  <= 1'b0;
            r_sv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_ack   <= w_accept;
            r_wake  <= w_wake_done;
            r_deep  <= w_deep_nxt;
            if (w_drain_entry) begin
                r_sv <= bus.sleep_value;
            end
        end
    end

    e203_wfi_sat_cnt #(
        .WIDTH (CNT_W)
    ) u_sleep_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_drain_entry),
        .i_en      (r_state == WFI_SLEEP),
        .o_cnt     (w_cnt),
        .o_cnt_nxt (w_cnt_nxt)
    );

    assign bus.wfi_ack        = r_ack;
    assign bus.wfi_wake       = r_wake;
    assign bus.halt_req       = (r_state != WFI_IDLE);
    assign bus.core_wfi       = (r_state == WFI_SLEEP);
    assign bus.deep_sleep_req = r_deep;
    assign bus.sleep_cnt      = w_cnt;
endmodule

// File: tb/tb_e203_wfi_ctrl.sv
// Bench for the WFI sequencer: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_e203_wfi_ctrl;
    localparam int CNT_W    = 16;
    localparam int WAKE_LAT = 2;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    e203_wfi_ctrl_if #(.CNT_W(CNT_W)) bus ();
    e203_wfi_ctrl_if #(.CNT_W(4))     bus4 ();

    e203_wfi_ctrl #(.CNT_W(CNT_W), .WAKE_LAT(WAKE_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    e203_wfi_ctrl #(.CNT_W(4), .WAKE_LAT(WAKE_LAT)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: "awake / draining / asleep / resuming" with an unbounded sleep tally
    // and a count of cycles left until resume.
    int     m_mode  = 0;
    int     m_left  = 0;
    longint m_slept = 0;
    bit     m_sv    = 1'b0;
    bit     e_ack = 1'b0, e_wake = 1'b0, e_halt = 1'b0, e_wfi = 1'b0, e_deep = 1'b0;
    longint e_cnt = 0;

    always @(posedge clk) begin
        bit woke;
        woke   = bus.irq_pending | bus.dbg_req;
        e_ack  = 1'b0;
        e_wake = 1'b0;
        if (!rst_n) begin
            m_mode  = 0;
            m_slept = 0;
            m_sv    = 1'b0;
        end else begin
            case (m_mode)
                0: if (bus.wfi_req) begin
                    e_ack = 1'b1;
                    if (woke) begin
                        m_mode = 3; m_left = WAKE_LAT + 1;
                    end else begin
                        m_mode = 1; m_sv = bus.sleep_value; m_slept = 0;
                    end
                end
                1: if (woke) begin
                    m_mode = 3; m_left = WAKE_LAT + 1;
                end else if (bus.pipe_idle) begin
                    m_mode = 2;
                end
                2: begin
                    m_slept++;
                    if (woke) begin
                        m_mode = 3; m_left = WAKE_LAT + 1;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        e_wake = 1'b1; m_mode = 0;
                    end
                end
            endcase
        end
        e_cnt  = (m_slept > CNT_MAX) ? CNT_MAX : m_slept;
        e_halt = (m_mode != 0);
        e_wfi  = (m_mode == 2);
        e_deep = (m_mode == 2) && m_sv && (bus.idle_thresh != 0) && (e_cnt >= longint'(bus.idle_thresh));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mdl_ack",  {31'd0, bus.wfi_ack},        {31'd0, e_ack});
            chk("mdl_wake", {31'd0, bus.wfi_wake},       {31'd0, e_wake});
            chk("mdl_halt", {31'd0, bus.halt_req},       {31'd0, e_halt});
            chk("mdl_wfi",  {31'd0, bus.core_wfi},       {31'd0, e_wfi});
            chk("mdl_deep", {31'd0, bus.deep_sleep_req}, {31'd0, e_deep});
            chk("mdl_cnt",  {16'd0, bus.sleep_cnt},      e_cnt[31:0]);
        end
    end

    task automatic enter_sleep(input bit sv, input int th);
        bus.sleep_value = sv;
        bus.idle_thresh = th[CNT_W-1:0];
        bus.pipe_idle   = 1'b1;
        bus.wfi_req     = 1'b1;
        step(1);
        chk("es_ack", {31'd0, bus.wfi_ack}, 32'd1);
        bus.wfi_req = 1'b0;
        step(1);
        chk("es_wfi", {31'd0, bus.core_wfi}, 32'd1);
    endtask

    task automatic run_sleep(input bit sv, input int th, input int n);
        enter_sleep(sv, th);
        for (int i = 0; i < n; i++) begin
            chk("rs_cnt",  {16'd0, bus.sleep_cnt}, i);
            chk("rs_deep", {31'd0, bus.deep_sleep_req}, {31'd0, (sv && th != 0 && i >= th)});
            if (i == n - 1) bus.irq_pending = 1'b1;
            step(1);
        end
        bus.irq_pending = 1'b0;
        chk("rs_cnt_final", {16'd0, bus.sleep_cnt}, n);
        chk("rs_deep_exit", {31'd0, bus.deep_sleep_req}, 32'd0);
        chk("rs_wfi_exit",  {31'd0, bus.core_wfi}, 32'd0);
        step(3);
        chk("rs_wake", {31'd0, bus.wfi_wake}, 32'd1);
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wfi_req = 0; bus.pipe_idle = 0; bus.irq_pending = 0; bus.dbg_req = 0;
        bus.sleep_value = 0; bus.idle_thresh = '0;
        bus4.wfi_req = 0; bus4.pipe_idle = 0; bus4.irq_pending = 0; bus4.dbg_req = 0;
        bus4.sleep_value = 0; bus4.idle_thresh = '0;
        rst_n = 1'b0;
        step(2);
        chk_en = 1'b1;
        chk("rst_halt", {31'd0, bus.halt_req}, 32'd0);
        chk("rst_wfi",  {31'd0, bus.core_wfi}, 32'd0);
        chk("rst_cnt",  {16'd0, bus.sleep_cnt}, 32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic sleep/wake with exact latencies
        enter_sleep(1'b0, 0);
        chk("t1_ack_once", {31'd0, bus.wfi_ack}, 32'd0);
        step(9);
        bus.irq_pending = 1'b1;
        step(1);
        bus.irq_pending = 1'b0;
        chk("t1_wfi_off", {31'd0, bus.core_wfi}, 32'd0);
        chk("t1_cnt",     {16'd0, bus.sleep_cnt}, 32'd10);
        chk("t1_halt",    {31'd0, bus.halt_req}, 32'd1);
        step(1); chk("t1_wake_early1", {31'd0, bus.wfi_wake}, 32'd0);
        step(1); chk("t1_wake_early2", {31'd0, bus.wfi_wake}, 32'd0);
        step(1); chk("t1_wake",        {31'd0, bus.wfi_wake}, 32'd1);
        chk("t1_halt_drop", {31'd0, bus.halt_req}, 32'd0);
        step(1);
        chk("t1_wake_once", {31'd0, bus.wfi_wake}, 32'd0);
        chk("t1_cnt_hold",  {16'd0, bus.sleep_cnt}, 32'd10);

        // Drain wait, then debug abort with priority over pipe_idle
        bus.pipe_idle = 1'b0;
        bus.wfi_req   = 1'b1;
        step(1);
        chk("t2_ack", {31'd0, bus.wfi_ack}, 32'd1);
        bus.wfi_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_wfi",  {31'd0, bus.core_wfi}, 32'd0);
            chk("t2_drain_halt", {31'd0, bus.halt_req}, 32'd1);
            step(1);
        end
        bus.pipe_idle = 1'b1;
        bus.dbg_req   = 1'b1;
        step(1);
        bus.dbg_req   = 1'b0;
        bus.pipe_idle = 1'b0;
        chk("t2_abort_wfi", {31'd0, bus.core_wfi}, 32'd0);
        chk("t2_abort_halt", {31'd0, bus.halt_req}, 32'd1);
        step(1); chk("t2_wfi_a", {31'd0, bus.core_wfi}, 32'd0);
        step(1); chk("t2_wfi_b", {31'd0, bus.core_wfi}, 32'd0);
        step(1); chk("t2_wake", {31'd0, bus.wfi_wake}, 32'd1);
        step(1);

        // Wake already pending when the request arrives
        bus.irq_pending = 1'b1;
        bus.wfi_req     = 1'b1;
        step(1);
        bus.irq_pending = 1'b0;
        bus.wfi_req     = 1'b0;
        chk("t3_ack", {31'd0, bus.wfi_ack}, 32'd1);
        chk("t3_wfi", {31'd0, bus.core_wfi}, 32'd0);
        step(2);
        chk("t3_wake_early", {31'd0, bus.wfi_wake}, 32'd0);
        step(1);
        chk("t3_wake", {31'd0, bus.wfi_wake}, 32'd1);
        step(1);

        // Deep sleep enabled, then disabled by sleep_value and by zero threshold
        run_sleep(1'b1, 100, 150);
        run_sleep(1'b0, 100, 120);
        run_sleep(1'b1, 0, 120);

        // Reset mid-SLEEP with deep_sleep_req high
        enter_sleep(1'b1, 5);
        step(8);
        chk("t5_deep_pre", {31'd0, bus.deep_sleep_req}, 32'd1);
        chk("t5_wfi_pre",  {31'd0, bus.core_wfi}, 32'd1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("t5_wfi",  {31'd0, bus.core_wfi}, 32'd0);
        chk("t5_deep", {31'd0, bus.deep_sleep_req}, 32'd0);
        chk("t5_halt", {31'd0, bus.halt_req}, 32'd0);
        chk("t5_cnt",  {16'd0, bus.sleep_cnt}, 32'd0);
        chk("t5_wake", {31'd0, bus.wfi_wake}, 32'd0);
        run_sleep(1'b0, 0, 3);

        // Saturation on the 4-bit instance
        bus4.pipe_idle = 1'b1;
        bus4.wfi_req   = 1'b1;
        step(1);
        chk("sat_ack", {31'd0, bus4.wfi_ack}, 32'd1);
        bus4.wfi_req = 1'b0;
        step(1);
        for (int i = 0; i < 40; i++) begin
            chk("sat_cnt", {28'd0, bus4.sleep_cnt}, (i > 15) ? 15 : i);
            if (i == 39) bus4.irq_pending = 1'b1;
            step(1);
        end
        bus4.irq_pending = 1'b0;
        chk("sat_final", {28'd0, bus4.sleep_cnt}, 32'd15);
        chk("sat_wfi",   {31'd0, bus4.core_wfi}, 32'd0);
        step(3);
        chk("sat_wake",  {31'd0, bus4.wfi_wake}, 32'd1);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
